lift_step_pipe: RTL
===================

Name: lift_step_pipe

Overview:
- Parametrised, pipelined lifting-step unit for the DWT datapath. It succeeds the fixed 24-bit combinational add/multiply step.
- Each beat takes a centre sample and its two neighbours and returns one lifted sample.
- Modes: Le Gall 5/3 integer (reversible) or 9/7 fixed-point (irreversible); forward or inverse.
- Valid/ready streaming, runtime-programmable 9/7 coefficients, sideband tag carried alongside each beat.

Parameters:
- W, 16, sample width (signed two's complement)
- CW, 18, coefficient width (signed)
- FRAC, 14, coefficient fractional bits
- TAG_W, 8, sideband tag width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input beat offered
- in_ready  out  1  input beat accepted when in_valid & in_ready
- x_l  in  W  left neighbour (signed)
- x_c  in  W  centre sample (signed)
- x_r  in  W  right neighbour (signed)
- mode97  in  1  0 = 5/3 integer, 1 = 9/7 fixed-point
- step  in  2  5/3: 0 = predict, 1 = update (bit1 ignored); 9/7: coefficient slot 0..3
- fwd  in  1  1 = forward, 0 = inverse
- tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- y  out  W  lifted sample (signed)
- y_tag  out  TAG_W  tag of the beat in y
- coef_we  in  1  coefficient write strobe
- coef_addr  in  2  slot index
- coef_data  in  CW  coefficient, Q(CW-FRAC).FRAC
- ovf_clr  in  1  clears ovf_sticky
- ovf_sticky  out  1  overflow seen since last clear

Behaviour:
- Reset (rst=1 at a clk edge) clears all stage valids, so out_valid=0. Also y=0, y_tag=0, ovf_sticky=0.
- Reset loads the coefficient slots, FRAC=14 values: 0 = -25987 (alpha), 1 = -868 (beta), 2 = 14466 (gamma), 3 = 7266 (delta).
- Reset mid-operation discards in-flight beats; no output is produced for them.
- Pipeline structure:
  - 3 stages with a global enable: en = !out_valid | out_ready; in_ready = en.
  - Bubbles are not compressed.
  - Latency is 3 cycles from acceptance to out_valid when en stays high.
  - y and y_tag hold stable while out_valid & !out_ready.
- S1 (registers on acceptance):
  - s = x_l + x_r, sign-extended to W+1 bits.
  - Registers x_c, mode, step, fwd, tag.
  - In 9/7 mode, registers coef = slot[step].
- S2:
  - 5/3 predict: t = s >>> 1.
  - 5/3 update: t = (s + 2) >>> 2.
  - 9/7: t = (s*coef + 2^(FRAC-1)) >>> FRAC.
  - All shifts are arithmetic (floor). t is W+1+CW bits signed.
- S3:
  - 5/3 predict: fwd → y = x_c - t; inverse → y = x_c + t.
  - 5/3 update: fwd → y = x_c + t; inverse → y = x_c - t.
  - 9/7: fwd → y = x_c + t; inverse → y = x_c - t.
  - The full-width result is then reduced to W bits (see Optional Feature).
  - Forward followed by inverse in 5/3 mode reproduces x_c exactly.
- Coefficient writes:
  - coef_we writes slot coef_addr at the clk edge.
  - A beat accepted in the same cycle as a write uses the old value.
  - Beats accepted later use the new value.
  - In-flight beats are never affected.
  - Writes are allowed at any time, including during a stall.
- ovf_clr and an overflow in the same cycle: the overflow wins, so ovf_sticky=1.
- Simultaneous in and out handshakes in a full pipeline sustain 1 beat/cycle.

Optional Feature:
- Macro LIFT_SAT_EN.
- Defined:
  - Out-of-range results clamp to [-2^(W-1), 2^(W-1)-1].
  - Any clamp sets ovf_sticky when that beat leaves S3, i.e. when S3 advances with a valid beat.
- Undefined:
  - y is the low W bits of the result (wrap-around).
  - ovf_sticky is tied 0 and ovf_clr is ignored.

Decomposition:
- Package lift_pkg holds:
  - step codes (STEP_PREDICT=0, STEP_UPDATE=1)
  - default coefficient constants ALPHA/BETA/GAMMA/DELTA_Q14
  - a function returning reset coefficients scaled to FRAC
- One natural sub-module: lift_coef_regs, the 4×CW register file with a sync write port, combinational read, and reset defaults.

Test Plan:
- 5/3 predict, W=16: fwd, x_l=10, x_c=7, x_r=5 → y=0 after 3 cycles. Inverse with x_c=0, same neighbours → y=7.
- 5/3 update: fwd, x_l=4, x_c=100, x_r=4 → y=102. Inverse, x_c=102 → y=100.
- 9/7 alpha: fwd, step=0, x_l=x_r=1000, x_c=0 → y=-3172. Tag 0x5A returned on y_tag.
- Backpressure: 4 back-to-back beats (tags 1..4) with out_ready=0 for 5 cycles:
  - in_ready drops once out_valid=1 and out_ready=0.
  - y stays stable while stalled.
  - After release, tags emerge 1,2,3,4 with nothing lost or duplicated.
- Coefficient write: coef_we with slot 0 = 16384 in the same cycle beat A is accepted; beat B is accepted next cycle. Both beats use x_l=x_r=5, x_c=0, step=0, fwd.
  - A → y=-16
  - B → y=10
  - Assert rst mid-stream → out_valid=0 the next cycle and no stale outputs.
- LIFT_SAT_EN: 5/3 update fwd, x_c=32767, x_l=x_r=100 → y=32767 and ovf_sticky=1. Then ovf_clr → 0.
  - With the macro undefined → y=-32719 and ovf_sticky=0.

Source files
------------

// File: rtl/lift_step_pipe_pkg.sv
// Shared constants for the DWT lifting-step pipeline: 5/3 step codes and
// the default 9/7 lifting coefficients.
package lift_pkg;

  typedef enum logic {
    STEP_PREDICT = 1'b0,
    STEP_UPDATE  = 1'b1
  } step53_e;

  localparam int DEF_FRAC  = 14;
  localparam int ALPHA_Q14 = -25987;
  localparam int BETA_Q14  = -868;
  localparam int GAMMA_Q14 = 14466;
  localparam int DELTA_Q14 = 7266;

  // Default coefficient for a slot, rescaled from Q.14 to `frac` fractional bits.
  function automatic int reset_coef(input logic [1:0] slot, input int frac);
    int q14;
    case (slot)
      2'd0:    q14 = ALPHA_Q14;
      2'd1:    q14 = BETA_Q14;
      2'd2:    q14 = GAMMA_Q14;
      default: q14 = DELTA_Q14;
    endcase
    if (frac >= DEF_FRAC) reset_coef = q14 <<< (frac - DEF_FRAC);
    else                  reset_coef = q14 >>> (DEF_FRAC - frac);
  endfunction

endpackage

// File: rtl/lift_step_pipe_if.sv
// Streaming bus of the lifting step: input beat with neighbours, mode and
// sideband tag, plus the lifted result returned to the consumer.
interface lift_step_pipe_if #(
  parameter int W     = 16,
  parameter int TAG_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  x_l;
  logic signed [W-1:0]  x_c;
  logic signed [W-1:0]  x_r;
  logic                 mode97;
  logic [1:0]           step;
  logic                 fwd;
  logic [TAG_W-1:0]     tag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W-1:0]  y;
  logic [TAG_W-1:0]     y_tag;

  modport master (
    output in_valid, x_l, x_c, x_r, mode97, step, fwd, tag, out_ready,
    input  in_ready, out_valid, y, y_tag
  );

  modport slave (
    input  in_valid, x_l, x_c, x_r, mode97, step, fwd, tag, out_ready,
    output in_ready, out_valid, y, y_tag
  );
endinterface

// File: rtl/lift_step_pipe_coef_regs.sv
// Four-slot 9/7 coefficient register file: synchronous write, combinational
// read, reset to the standard alpha/beta/gamma/delta values.
module lift_coef_regs
  import lift_pkg::*;
#(
  parameter int CW   = 18,
  parameter int FRAC = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [1:0]           waddr_i,
  input  logic signed [CW-1:0] wdata_i,
  input  logic [1:0]           raddr_i,
  output logic signed [CW-1:0] rdata_o
);

  logic signed [CW-1:0] coef_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) coef_q[i] <= CW'(reset_coef(2'(i), FRAC));
    end else if (we_i) begin
      coef_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = coef_q[raddr_i];

endmodule

// File: rtl/lift_step_pipe.sv
// Three-stage lifting step (5/3 integer or 9/7 fixed-point, fwd/inverse).
// Define LIFT_SAT_EN to clamp results and track overflow in ovf_sticky.
module lift_step_pipe
  import lift_pkg::*;
#(
  parameter int W     = 16,
  parameter int CW    = 18,
  parameter int FRAC  = 14,
  parameter int TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  lift_step_pipe_if.slave      bus,
  input  logic                 coef_we,
  input  logic [1:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 ovf_clr,
  output logic                 ovf_sticky
);

  localparam int STAGES = 3;
  localparam int TW     = W + 1 + CW;
  localparam int YW     = TW + 1;
  localparam logic signed [TW-1:0] RND = TW'(1) << (FRAC - 1);
  localparam logic signed [TW-1:0] TWO = TW'(2);

  logic en;
  logic [STAGES:1] vld_q;

  // One global enable: the whole pipe moves or the whole pipe holds.
  assign en            = !vld_q[STAGES] | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_q[STAGES];

  logic signed [CW-1:0] coef_rd;

  lift_coef_regs #(.CW(CW), .FRAC(FRAC)) u_coef (
    .clk     (clk),
    .rst     (rst),
    .we_i    (coef_we),
    .waddr_i (coef_addr),
    .wdata_i (coef_data),
    .raddr_i (bus.step),
    .rdata_o (coef_rd)
  );

  logic signed [W:0]     s1_d, s1_q;
  logic signed [W-1:0]   xc1_q, xc2_q;
  logic                  m97_1_q, step1_q, fwd1_q;
  logic signed [CW-1:0]  coef1_q;
  logic [TAG_W-1:0]      tag1_q, tag2_q, tag3_q;
  logic signed [TW-1:0]  s_ext, c_ext, prod, t2_d, t2_q;
  logic                  sub1, sub2_q;
  logic signed [YW-1:0]  xc_ext, t_ext, sum;
  logic signed [W-1:0]   y_d, y_q;

  assign s1_d = {bus.x_l[W-1], bus.x_l} + {bus.x_r[W-1], bus.x_r};

  assign s_ext = {{CW{s1_q[W]}}, s1_q};
  assign c_ext = {{(W+1){coef1_q[CW-1]}}, coef1_q};
  assign prod  = s_ext * c_ext;

  always_comb begin
    t2_d = s_ext >>> 1;
    sub1 = !fwd1_q;
    if (m97_1_q) begin
      t2_d = (prod + RND) >>> FRAC;
    end else if (step53_e'(step1_q) == STEP_PREDICT) begin
      sub1 = fwd1_q;
    end else begin
      t2_d = (s_ext + TWO) >>> 2;
    end
  end

  assign xc_ext = {{(YW-W){xc2_q[W-1]}}, xc2_q};
  assign t_ext  = {t2_q[TW-1], t2_q};
  assign sum    = sub2_q ? (xc_ext - t_ext) : (xc_ext + t_ext);

`ifdef LIFT_SAT_EN
  localparam logic signed [YW-1:0] YMAX = YW'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [YW-1:0] YMIN = ~YMAX;

  logic clamp, ovf_d, ovf_q;

  always_comb begin
    clamp = 1'b0;
    y_d   = sum[W-1:0];
    if (sum > YMAX) begin
      y_d   = YMAX[W-1:0];
      clamp = 1'b1;
    end else if (sum < YMIN) begin
      y_d   = YMIN[W-1:0];
      clamp = 1'b1;
    end
  end

  // A new overflow outranks a clear in the same cycle.
  assign ovf_d = (ovf_q & ~ovf_clr) | (en & vld_q[STAGES-1] & clamp);

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf_sticky = ovf_q;
`else
  logic ovf_unused;

  assign y_d        = sum[W-1:0];
  assign ovf_sticky = 1'b0;
  assign ovf_unused = ovf_clr | (^sum[YW-1:W]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      s1_q    <= '0;
      xc1_q   <= '0;
      m97_1_q <= 1'b0;
      step1_q <= 1'b0;
      fwd1_q  <= 1'b0;
      tag1_q  <= '0;
      coef1_q <= '0;
      t2_q    <= '0;
      xc2_q   <= '0;
      sub2_q  <= 1'b0;
      tag2_q  <= '0;
      y_q     <= '0;
      tag3_q  <= '0;
    end else if (en) begin
      vld_q   <= {vld_q[STAGES-1:1], bus.in_valid};
      s1_q    <= s1_d;
      xc1_q   <= bus.x_c;
      m97_1_q <= bus.mode97;
      step1_q <= bus.step[0];
      fwd1_q  <= bus.fwd;
      tag1_q  <= bus.tag;
      // Coefficient is snapshotted at acceptance so later writes never reach in-flight beats.
      if (bus.mode97) coef1_q <= coef_rd;
      t2_q    <= t2_d;
      xc2_q   <= xc1_q;
      sub2_q  <= sub1;
      tag2_q  <= tag1_q;
      y_q     <= y_d;
      tag3_q  <= tag2_q;
    end
  end

  assign bus.y     = y_q;
  assign bus.y_tag = tag3_q;

endmodule
